clock_set_ctrl: RTL and testbench

//  Controller that sequences the clock (hh:mm:ss) counter datapath: generates its 1 Hz tick enable, runs the

---
 rtl/clock_pkg.sv | 20 ++
 rtl/clock_set_ctrl_if.sv | 46 ++++
 rtl/clock_prescaler.sv | 37 +++
 rtl/clock_set_ctrl.sv | 121 ++++++++++++
 tb/tb_clock_set_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Package: clock_pkg
// Shared types and constants for the clock set controller slice.
//   state_t      - time-set FSM encoding (RUN=0, SET_HRS=1, SET_MIN=2, COMMIT=3)
//   TIME_W       - width of every time field exchanged with the clock counter
//   HRS_MAX_DEF  - default hours modulus
//   MIN_MAX_DEF  - default minutes modulus
package clock_pkg;

    localparam int TIME_W      = 32;
    localparam int HRS_MAX_DEF = 24;
    localparam int MIN_MAX_DEF = 60;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HRS = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Interface: clock_set_ctrl_if
// Bundles the controller's button inputs, counter feedback and counter
// command outputs.
//   master - used by clock_set_ctrl (drives tick/load/state)
//   slave  - used by the surrounding logic (drives buttons and cur_*)
// Optional build macro CLOCK_ALARM_EN adds io_alarm_hrs, io_alarm_min and
// io_alarm.
interface clock_set_ctrl_if;
    import clock_pkg::*;

    logic              io_mode;
    logic              io_inc;
    logic [TIME_W-1:0] io_cur_sec;
    logic [TIME_W-1:0] io_cur_min;
    logic [TIME_W-1:0] io_cur_hrs;
    logic              io_tick_en;
    logic              io_load;
    logic [TIME_W-1:0] io_load_sec;
    logic [TIME_W-1:0] io_load_min;
    logic [TIME_W-1:0] io_load_hrs;
    logic [1:0]        io_state;
`ifdef CLOCK_ALARM_EN
    logic [TIME_W-1:0] io_alarm_hrs;
    logic [TIME_W-1:0] io_alarm_min;
    logic              io_alarm;
`endif

    modport master (
        input  io_mode, io_inc, io_cur_sec, io_cur_min, io_cur_hrs,
`ifdef CLOCK_ALARM_EN
        input  io_alarm_hrs, io_alarm_min,
        output io_alarm,
`endif
        output io_tick_en, io_load, io_load_sec, io_load_min, io_load_hrs, io_state
    );

    modport slave (
        output io_mode, io_inc, io_cur_sec, io_cur_min, io_cur_hrs,
`ifdef CLOCK_ALARM_EN
        output io_alarm_hrs, io_alarm_min,
        input  io_alarm,
`endif
        input  io_tick_en, io_load, io_load_sec, io_load_min, io_load_hrs, io_state
    );

endinterface

// File: rtl/clock_prescaler.sv
// Module: clock_prescaler
// Divides clk down to a one-cycle tick every TICK_DIV cycles while enabled.
//   clk     - clock
//   rst_n   - synchronous active-low reset
//   enable  - count while high; counter held at 0 while low
//   restart - force the counter back to 0 (start a full period)
//   tick    - high while the counter sits at TICK_DIV-1 and enable is high
module clock_prescaler #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: reset is sampled on the clock edge (synchronous), so it lives
    // inside the clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable || restart) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/clock_set_ctrl.sv
// Module: clock_set_ctrl
// Sequences the hh:mm:ss counter: issues its 1 Hz tick enable, runs the
// time-set FSM driven by debounced mode/inc pulses, and strobes a one-cycle
// load of the edited time back into the counter.
//   io_clock - clock (rising edge)
//   io_reset - synchronous active-low reset
//   bus      - clock_set_ctrl_if.master: buttons, cur_* feedback, tick/load
//              commands, load values and FSM state
// Optional build macro CLOCK_ALARM_EN adds a registered hh:mm alarm compare.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned HRS_MAX  = HRS_MAX_DEF,
    parameter int unsigned MIN_MAX  = MIN_MAX_DEF
) (
    input  logic             io_clock,
    input  logic             io_reset,
    clock_set_ctrl_if.master bus
);

    localparam int HRS_W = $clog2(HRS_MAX);
    localparam int MIN_W = $clog2(MIN_MAX);
    localparam logic [HRS_W-1:0] HRS_LAST = HRS_W'(HRS_MAX - 1);
    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_MAX - 1);

    state_t           state;
    logic [HRS_W-1:0] edit_hrs;
    logic [MIN_W-1:0] edit_min;
    logic             load_q;
    logic [HRS_W-1:0] snap_hrs;
    logic [MIN_W-1:0] snap_min;
    logic             unused_cur_sec;

    // Seconds feedback is not needed: a load always restarts at :00.
    assign unused_cur_sec = ^bus.io_cur_sec;

    // Out-of-range counter values snapshot as 0 so the edit regs never
    // hold an illegal time.
    assign snap_hrs = (bus.io_cur_hrs >= TIME_W'(HRS_MAX)) ? '0 : bus.io_cur_hrs[HRS_W-1:0];
    assign snap_min = (bus.io_cur_min >= TIME_W'(MIN_MAX)) ? '0 : bus.io_cur_min[MIN_W-1:0];

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge io_clock) begin
        if (!io_reset) begin
            state    <= RUN;
            edit_hrs <= '0;
            edit_min <= '0;
            load_q   <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (state)
                RUN: begin
                    if (bus.io_mode) begin
                        state    <= SET_HRS;
                        edit_hrs <= snap_hrs;
                        edit_min <= snap_min;
                    end
                end
                SET_HRS: begin
                    // mode has priority; a simultaneous inc is dropped
                    if (bus.io_mode) begin
                        state <= SET_MIN;
                    end else if (bus.io_inc) begin
                        edit_hrs <= (edit_hrs == HRS_LAST) ? '0 : edit_hrs + HRS_W'(1);
                    end
                end
                SET_MIN: begin
                    if (bus.io_mode) begin
                        state  <= COMMIT;
                        load_q <= 1'b1;
                    end else if (bus.io_inc) begin
                        edit_min <= (edit_min == MIN_LAST) ? '0 : edit_min + MIN_W'(1);
                    end
                end
                COMMIT: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Restart on the load cycle so the first second after a load is a full
    // TICK_DIV period.
    clock_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (io_clock),
        .rst_n   (io_reset),
        .enable  (state == RUN),
        .restart (load_q),
        .tick    (bus.io_tick_en)
    );

    assign bus.io_load     = load_q;
    assign bus.io_state    = state;
    assign bus.io_load_sec = '0;
    assign bus.io_load_hrs = TIME_W'(edit_hrs);
    assign bus.io_load_min = TIME_W'(edit_min);

`ifdef CLOCK_ALARM_EN
    logic alarm_q;

    always_ff @(posedge io_clock) begin
        if (!io_reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= (state == RUN) &&
                       (bus.io_cur_hrs == bus.io_alarm_hrs) &&
                       (bus.io_cur_min == bus.io_alarm_min);
        end
    end

    assign bus.io_alarm = alarm_q;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Testbench: tb_clock_set_ctrl
// Directed vectors with hand-computed expectations for clock_set_ctrl
// (TICK_DIV=10). Covers the alarm path when CLOCK_ALARM_EN is defined.
module tb_clock_set_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    bit   seen;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(
        .TICK_DIV (10),
        .HRS_MAX  (24),
        .MIN_MAX  (60)
    ) dut (
        .io_clock (clk),
        .io_reset (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle outputs before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n           = 1'b0;
        bus.io_mode     = 1'b0;
        bus.io_inc      = 1'b0;
        bus.io_cur_hrs  = 32'd13;
        bus.io_cur_min  = 32'd45;
        bus.io_cur_sec  = 32'd7;
`ifdef CLOCK_ALARM_EN
        bus.io_alarm_hrs = 32'd7;
        bus.io_alarm_min = 32'd30;
`endif

        // Reset state
        step_n(2);
        check("rst_state", 32'(bus.io_state), 32'd0);
        check("rst_load", 32'(bus.io_load), 32'd0);
        check("rst_tick", 32'(bus.io_tick_en), 32'd0);
        check("rst_load_hrs", bus.io_load_hrs, 32'd0);
        check("rst_load_min", bus.io_load_min, 32'd0);
        check("rst_load_sec", bus.io_load_sec, 32'd0);

        // Prescaler: tick visible after edges 9 and 19, sampled on 10th/20th
        rst_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            check($sformatf("tick_e%0d", n), 32'(bus.io_tick_en), 32'((n % 10) == 9));
        end
        check("run_state", 32'(bus.io_state), 32'd0);

        // Enter SET_HRS, snapshot 13:45
        bus.io_mode = 1'b1;
        step();
        bus.io_mode = 1'b0;
        check("sethrs_state", 32'(bus.io_state), 32'd1);
        check("snap_hrs", bus.io_load_hrs, 32'd13);
        check("snap_min", bus.io_load_min, 32'd45);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.io_tick_en) seen = 1'b1;
        end
        check("no_tick_in_set", 32'(seen), 32'd0);

        // Hours 13 -> 23, then wrap 0, 1
        bus.io_inc = 1'b1;
        step_n(10);
        check("hrs_23", bus.io_load_hrs, 32'd23);
        step();
        check("hrs_wrap0", bus.io_load_hrs, 32'd0);
        step();
        check("hrs_1", bus.io_load_hrs, 32'd1);
        bus.io_inc  = 1'b0;
        bus.io_mode = 1'b1;
        step();
        bus.io_mode = 1'b0;
        check("setmin_state", 32'(bus.io_state), 32'd2);
        check("hrs_kept", bus.io_load_hrs, 32'd1);

        // Minutes 45 -> 59, wrap 0, then 1
        bus.io_inc = 1'b1;
        step_n(14);
        check("min_59", bus.io_load_min, 32'd59);
        step();
        check("min_wrap0", bus.io_load_min, 32'd0);
        step();
        check("min_1", bus.io_load_min, 32'd1);
        bus.io_inc = 1'b0;

        // Commit: one-cycle load of 01:01:00
        bus.io_mode = 1'b1;
        step();
        check("commit_state", 32'(bus.io_state), 32'd3);
        check("commit_load", 32'(bus.io_load), 32'd1);
        check("commit_hrs", bus.io_load_hrs, 32'd1);
        check("commit_min", bus.io_load_min, 32'd1);
        check("commit_sec", bus.io_load_sec, 32'd0);
        // mode/inc during COMMIT are ignored
        bus.io_inc = 1'b1;
        step();
        bus.io_mode = 1'b0;
        bus.io_inc  = 1'b0;
        check("post_commit_state", 32'(bus.io_state), 32'd0);
        check("post_commit_load", 32'(bus.io_load), 32'd0);
        check("post_commit_hrs", bus.io_load_hrs, 32'd1);
        seen = 1'b0;
        for (int m = 1; m <= 9; m++) begin
            step();
            if (bus.io_load) seen = 1'b1;
            check($sformatf("tick_after_load_%0d", m), 32'(bus.io_tick_en), 32'(m == 9));
        end
        check("single_load", 32'(seen), 32'd0);

        // mode+inc together in SET_HRS: mode wins
        bus.io_mode = 1'b1;
        step();
        check("re_sethrs", 32'(bus.io_state), 32'd1);
        bus.io_inc = 1'b1;
        step();
        bus.io_mode = 1'b0;
        bus.io_inc  = 1'b0;
        check("mode_inc_state", 32'(bus.io_state), 32'd2);
        check("mode_inc_hrs", bus.io_load_hrs, 32'd13);

        // Reset mid-edit in SET_MIN: back to RUN, no load
        rst_n = 1'b0;
        step();
        check("midrst_state", 32'(bus.io_state), 32'd0);
        check("midrst_load", 32'(bus.io_load), 32'd0);
        check("midrst_hrs", bus.io_load_hrs, 32'd0);
        check("midrst_min", bus.io_load_min, 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.io_load) seen = 1'b1;
        end
        check("midrst_noload", 32'(seen), 32'd0);
        check("midrst_run", 32'(bus.io_state), 32'd0);

        // Snapshot of out-of-range feedback (24:60) gives 00:00
        bus.io_cur_hrs = 32'd24;
        bus.io_cur_min = 32'd60;
        bus.io_mode    = 1'b1;
        step();
        bus.io_mode = 1'b0;
        check("oor_hrs", bus.io_load_hrs, 32'd0);
        check("oor_min", bus.io_load_min, 32'd0);
        // 23:59 is in range and snapshots unchanged
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.io_cur_hrs = 32'd23;
        bus.io_cur_min = 32'd59;
        bus.io_mode    = 1'b1;
        step();
        bus.io_mode = 1'b0;
        check("max_hrs", bus.io_load_hrs, 32'd23);
        check("max_min", bus.io_load_min, 32'd59);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

`ifdef CLOCK_ALARM_EN
        check("alarm_rst", 32'(bus.io_alarm), 32'd0);
        bus.io_cur_hrs = 32'd7;
        bus.io_cur_min = 32'd29;
        step();
        check("alarm_0729", 32'(bus.io_alarm), 32'd0);
        bus.io_cur_min = 32'd30;
        step();
        check("alarm_0730", 32'(bus.io_alarm), 32'd1);
        step();
        check("alarm_hold", 32'(bus.io_alarm), 32'd1);
        bus.io_cur_min = 32'd31;
        step();
        check("alarm_0731", 32'(bus.io_alarm), 32'd0);
        bus.io_cur_min = 32'd30;
        step();
        check("alarm_again", 32'(bus.io_alarm), 32'd1);
        bus.io_mode = 1'b1;
        step();
        bus.io_mode = 1'b0;
        check("alarm_mode_edge", 32'(bus.io_alarm), 32'd1);
        step();
        check("alarm_in_set", 32'(bus.io_alarm), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("alarm_reset", 32'(bus.io_alarm), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
